// File: rtl/cpu_bus_seq.sv
// Multi-beat little-endian operand sequencer between the 65832 execution FSM and the byte-wide bus.
// Optional read sign extension is enabled by defining CPU_BUS_SEQ_SEXT_EN.
module cpu_bus_seq #(
  parameter int  ADDR_W    = 32,
  parameter int  MAX_BYTES = 4,
  parameter int  TIMEOUT   = 64,
  localparam int DATA_W    = 8 * MAX_BYTES
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic              i_zp_wrap,
  input  logic              i_sext,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_bus_cyc,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [7:0]        o_bus_data,
  input  logic [7:0]        i_bus_data,
  input  logic              i_bus_data_ready
);

  localparam int BEAT_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic                lat_we;
  logic                lat_zp;
  logic [1:0]          lat_size;
  logic [DATA_W-1:0]   lat_wdata;
  logic [ADDR_W-1:0]   beat_addr;
  logic [BEAT_W-1:0]   beat_k;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

`ifdef CPU_BUS_SEQ_SEXT_EN
  logic                lat_sext;
`else
  logic                unused_sext;
  assign unused_sext = i_sext;
`endif

  logic                accept;
  logic                size_bad;
  logic [BEAT_W-1:0]   last_beat;
  logic                beat_last;
  logic                timeout_hit;
  logic [ADDR_W-1:0]   addr_inc;

  assign accept      = (state == S_IDLE) && i_req;
  assign size_bad    = (1 << i_size) > MAX_BYTES;
  assign last_beat   = BEAT_W'((1 << lat_size) - 1);
  assign beat_last   = (beat_k == last_beat);
  // Ready in the final wait cycle completes the beat instead of aborting it.
  assign timeout_hit = (TIMEOUT != 0) && (state == S_BEAT) && !i_bus_data_ready
                       && (wait_cnt == WAIT_LAST);
  assign addr_inc    = lat_zp ? {beat_addr[ADDR_W-1:8], beat_addr[7:0] + 8'd1}
                              : beat_addr + ADDR_W'(1);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_req) state_nxt = size_bad ? S_DONE : S_BEAT;
      S_BEAT: begin
        if (i_bus_data_ready && beat_last) state_nxt = S_DONE;
        else if (timeout_hit)              state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state != S_IDLE);
    o_done     = (state == S_DONE);
    o_err      = err_q;
    o_rdata    = rdata_q;
    o_bus_cyc  = (state == S_BEAT);
    o_bus_we   = (state == S_BEAT) && lat_we;
    o_bus_addr = (state == S_BEAT) ? beat_addr : '0;
    o_bus_data = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if ((state == S_BEAT) && (beat_k == BEAT_W'(b))) o_bus_data = lat_wdata[b*8 +: 8];
    end
  end

  // NOTE: the wide operand registers are reset as well so every output is 0 out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lat_we    <= 1'b0;
      lat_zp    <= 1'b0;
      lat_size  <= '0;
      lat_wdata <= '0;
      beat_addr <= '0;
      beat_k    <= '0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef CPU_BUS_SEQ_SEXT_EN
      lat_sext  <= 1'b0;
`endif
    end else if (accept) begin
      lat_we    <= i_we;
      lat_zp    <= i_zp_wrap;
      lat_size  <= i_size;
      lat_wdata <= i_wdata;
      beat_addr <= i_addr;
      beat_k    <= '0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
      err_q     <= size_bad;
`ifdef CPU_BUS_SEQ_SEXT_EN
      lat_sext  <= i_sext;
`endif
    end else if (state == S_BEAT) begin
      if (i_bus_data_ready) begin
        for (int b = 0; b < MAX_BYTES; b++) begin
          if (!lat_we && (beat_k == BEAT_W'(b))) begin
            rdata_q[b*8 +: 8] <= i_bus_data;
          end
`ifdef CPU_BUS_SEQ_SEXT_EN
          // Fill the bytes above the operand from the sign bit of the final byte.
          else if (!lat_we && lat_sext && beat_last && (BEAT_W'(b) > beat_k)) begin
            rdata_q[b*8 +: 8] <= {8{i_bus_data[7]}};
          end
`endif
        end
        wait_cnt <= '0;
        if (!beat_last) begin
          beat_k    <= beat_k + BEAT_W'(1);
          beat_addr <= addr_inc;
        end
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end else if (TIMEOUT != 0) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_seq.sv
// Scoreboard bench for cpu_bus_seq: directed transactions push expected beats and completions,
// a negedge monitor pops and compares them as the DUT presents bus beats and o_done.
module tb_cpu_bus_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [1:0]  i_size;
  logic        i_zp_wrap;
  logic        i_sext;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_rdata;
  logic        o_bus_cyc;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [7:0]  o_bus_data;
  logic [7:0]  i_bus_data;
  logic        i_bus_data_ready;

  cpu_bus_seq dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_req            (i_req),
    .i_we             (i_we),
    .i_addr           (i_addr),
    .i_size           (i_size),
    .i_zp_wrap        (i_zp_wrap),
    .i_sext           (i_sext),
    .i_wdata          (i_wdata),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err            (o_err),
    .o_rdata          (o_rdata),
    .o_bus_cyc        (o_bus_cyc),
    .o_bus_we         (o_bus_we),
    .o_bus_addr       (o_bus_addr),
    .o_bus_data       (o_bus_data),
    .i_bus_data       (i_bus_data),
    .i_bus_data_ready (i_bus_data_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          stall;
    int          acc;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  data;
    int          len;
  } beat_t;

  done_t done_q[$];
  beat_t beat_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] rd_bytes[8];
  int         stall_plan[8];
  logic       idle_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Bus responder: per-beat stall count, then ready with the planned byte.
  initial begin : responder
    int  beat_idx;
    int  stall_cnt;
    logic fired;
    beat_idx  = 0;
    stall_cnt = 0;
    fired     = 1'b0;
    i_bus_data_ready = 1'b0;
    i_bus_data       = 8'h00;
    forever begin
      @(posedge i_clk);
      #1;
      if (fired) begin
        beat_idx++;
        stall_cnt = 0;
      end
      fired = 1'b0;
      if (o_bus_cyc && beat_idx < 8) begin
        if (stall_cnt < stall_plan[beat_idx]) begin
          i_bus_data_ready = 1'b0;
          stall_cnt++;
        end else begin
          i_bus_data_ready = 1'b1;
          i_bus_data       = rd_bytes[beat_idx];
          fired            = 1'b1;
        end
      end else begin
        beat_idx         = 0;
        stall_cnt        = 0;
        i_bus_data_ready = idle_ready;
        i_bus_data       = 8'hA5;
      end
    end
  end

  // Monitor: compares completed beats and completions against the scoreboard.
  initial begin : monitor
    int    run_len;
    beat_t b;
    done_t d;
    run_len = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        run_len = 0;
      end else begin
        if (o_bus_cyc) begin
          run_len++;
          if (i_bus_data_ready) begin
            if (beat_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_beat: addr 0x%0h with no beat expected", o_bus_addr);
            end else begin
              b = beat_q.pop_front();
              check("beat_addr", 64'(o_bus_addr), 64'(b.addr));
              check("beat_we",   64'(o_bus_we),   64'(b.we));
              check("beat_data", 64'(o_bus_data), 64'(b.data));
              check("beat_len",  64'(run_len),    64'(b.len));
            end
            run_len = 0;
          end
        end
        if (o_done) begin
          if (done_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: err %0d rdata 0x%0h with none expected", o_err, o_rdata);
          end else begin
            d = done_q.pop_front();
            check("done_err",     64'(o_err),        64'(d.err));
            check("done_rdata",   64'(o_rdata),      64'(d.rdata));
            check("done_latency", 64'(cyc - d.acc),  64'(d.lat));
            if (d.stall != 0) check("timeout_stall_len", 64'(run_len), 64'(d.stall));
          end
          run_len = 0;
        end
      end
    end
  end

  task automatic exp_beat(input logic [31:0] addr, input logic we, input logic [7:0] data,
                          input int len);
    beat_t b;
    b.addr = addr;
    b.we   = we;
    b.data = data;
    b.len  = len;
    beat_q.push_back(b);
  endtask

  task automatic set_rd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3);
    rd_bytes[0] = b0;
    rd_bytes[1] = b1;
    rd_bytes[2] = b2;
    rd_bytes[3] = b3;
  endtask

  task automatic set_stall(input int s0, input int s1, input int s2, input int s3);
    stall_plan[0] = s0;
    stall_plan[1] = s1;
    stall_plan[2] = s2;
    stall_plan[3] = s3;
  endtask

  // Called at a negedge: raises i_req for exactly one sampling edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic zp, input logic sext, input logic [31:0] wdata,
                       input logic push, input logic err, input logic [31:0] rdata,
                       input int lat, input int stall);
    done_t d;
    d.err   = err;
    d.rdata = rdata;
    d.lat   = lat;
    d.stall = stall;
    d.acc   = cyc;
    if (push) done_q.push_back(d);
    i_we      = we;
    i_addr    = addr;
    i_size    = size;
    i_zp_wrap = zp;
    i_sext    = sext;
    i_wdata   = wdata;
    i_req     = 1'b1;
    @(posedge i_clk);
    #1;
    i_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (o_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_done_timeout: no o_done within 200 cycles", name);
    end
    @(negedge i_clk);
    check({name, "_idle_after_done"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_req = 1'b0;
    i_we = 1'b0;
    i_addr = '0;
    i_size = '0;
    i_zp_wrap = 1'b0;
    i_sext = 1'b0;
    i_wdata = '0;
    set_rd(8'h00, 8'h00, 8'h00, 8'h00);
    set_stall(0, 0, 0, 0);
    for (int i = 4; i < 8; i++) begin
      rd_bytes[i]   = 8'h00;
      stall_plan[i] = 0;
    end

    repeat (3) @(negedge i_clk);
    check("rst_busy",     64'(o_busy),     64'd0);
    check("rst_done",     64'(o_done),     64'd0);
    check("rst_err",      64'(o_err),      64'd0);
    check("rst_rdata",    64'(o_rdata),    64'd0);
    check("rst_bus_cyc",  64'(o_bus_cyc),  64'd0);
    check("rst_bus_we",   64'(o_bus_we),   64'd0);
    check("rst_bus_addr", 64'(o_bus_addr), 64'd0);
    check("rst_bus_data", 64'(o_bus_data), 64'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // 4-byte read, ready always high; o_bus_data mirrors the latched write operand.
    set_rd(8'h11, 8'h22, 8'h33, 8'h44);
    set_stall(0, 0, 0, 0);
    exp_beat(32'h0000_1234, 1'b0, 8'h0D, 1);
    exp_beat(32'h0000_1235, 1'b0, 8'hF0, 1);
    exp_beat(32'h0000_1236, 1'b0, 8'hFE, 1);
    exp_beat(32'h0000_1237, 1'b0, 8'hCA, 1);
    issue(1'b0, 32'h0000_1234, 2'd2, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h4433_2211, 5, 0);
    wait_done("rd4");

    // 2-byte write across the zero-page boundary, wrapping and not wrapping.
    exp_beat(32'h0000_00FF, 1'b1, 8'hEF, 1);
    exp_beat(32'h0000_0000, 1'b1, 8'hBE, 1);
    issue(1'b1, 32'h0000_00FF, 2'd1, 1'b1, 1'b0, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0, 3, 0);
    wait_done("wr2_zp");
    exp_beat(32'h0000_00FF, 1'b1, 8'hEF, 1);
    exp_beat(32'h0000_0100, 1'b1, 8'hBE, 1);
    issue(1'b1, 32'h0000_00FF, 2'd1, 1'b0, 1'b0, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0, 3, 0);
    wait_done("wr2_lin");

    // Zero-page wrap keeps the upper address bits.
    set_rd(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    exp_beat(32'h1234_56FF, 1'b0, 8'h00, 1);
    exp_beat(32'h1234_5600, 1'b0, 8'h00, 1);
    exp_beat(32'h1234_5601, 1'b0, 8'h00, 1);
    exp_beat(32'h1234_5602, 1'b0, 8'h00, 1);
    issue(1'b0, 32'h1234_56FF, 2'd2, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'hD4C3_B2A1, 5, 0);
    wait_done("rd4_zp");

    // Single-byte read with 3 stall cycles; a request while busy must be ignored.
    set_rd(8'h7E, 8'h00, 8'h00, 8'h00);
    set_stall(3, 0, 0, 0);
    exp_beat(32'h0000_0040, 1'b0, 8'h00, 4);
    issue(1'b0, 32'h0000_0040, 2'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_007E, 5, 0);
    i_addr = 32'h0000_9999;
    i_req  = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_req = 1'b0;
    wait_done("rd1_stall");

    // Beat 1 never ready: abort after 64 stall cycles, byte 0 kept.
    set_rd(8'h5A, 8'h00, 8'h00, 8'h00);
    set_stall(0, 1000, 0, 0);
    exp_beat(32'h0000_2000, 1'b0, 8'h00, 1);
    issue(1'b0, 32'h0000_2000, 2'd2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_005A, 66, 64);
    wait_done("timeout");

    // Ready in the last cycle before timeout completes normally.
    set_rd(8'h3C, 8'h00, 8'h00, 8'h00);
    set_stall(63, 0, 0, 0);
    exp_beat(32'h0000_3000, 1'b0, 8'h00, 64);
    issue(1'b0, 32'h0000_3000, 2'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_003C, 65, 0);
    wait_done("edge_ready");

    // Illegal size: error on cycle 1 with no bus beat, o_rdata cleared.
    set_stall(0, 0, 0, 0);
    issue(1'b0, 32'h0000_4000, 2'd3, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1, 0);
    wait_done("bad_size");

    // Sign-extend request on a negative byte.
    set_rd(8'h80, 8'h00, 8'h00, 8'h00);
    exp_beat(32'h0000_5000, 1'b0, 8'h00, 1);
`ifdef CPU_BUS_SEQ_SEXT_EN
    issue(1'b0, 32'h0000_5000, 2'd0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF80, 2, 0);
`else
    issue(1'b0, 32'h0000_5000, 2'd0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0080, 2, 0);
`endif
    wait_done("sext1");
    exp_beat(32'h0000_5000, 1'b0, 8'h00, 1);
    issue(1'b0, 32'h0000_5000, 2'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0080, 2, 0);
    wait_done("sext0");

    // Ready while idle has no effect.
    idle_ready = 1'b1;
    repeat (4) begin
      @(negedge i_clk);
      check("idle_ready_busy", 64'(o_busy), 64'd0);
    end
    idle_ready = 1'b0;
    @(negedge i_clk);

    // Reset during beat 2 aborts at once with no completion.
    set_rd(8'h01, 8'h02, 8'h03, 8'h04);
    set_stall(0, 0, 10, 0);
    exp_beat(32'h0000_6000, 1'b0, 8'h00, 1);
    exp_beat(32'h0000_6001, 1'b0, 8'h00, 1);
    issue(1'b0, 32'h0000_6000, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0, 0);
    repeat (3) @(negedge i_clk);
    check("pre_rst_cyc", 64'(o_bus_cyc), 64'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_cyc",   64'(o_bus_cyc),  64'd0);
    check("async_rst_busy",  64'(o_busy),     64'd0);
    check("async_rst_addr",  64'(o_bus_addr), 64'd0);
    check("async_rst_rdata", 64'(o_rdata),    64'd0);
    check("async_rst_done",  64'(o_done),     64'd0);
    repeat (2) begin
      @(negedge i_clk);
      check("rst_no_done", 64'(o_done), 64'd0);
    end
    i_rst = 1'b0;
    check("rst_beats_consumed", 64'(beat_q.size()), 64'd0);
    @(negedge i_clk);

    // Recovery after reset.
    set_stall(0, 0, 0, 0);
    exp_beat(32'h0000_0010, 1'b1, 8'h99, 1);
    issue(1'b1, 32'h0000_0010, 2'd0, 1'b0, 1'b0, 32'h0000_0099, 1'b1, 1'b0, 32'h0, 2, 0);
    wait_done("recover");

    repeat (2) @(negedge i_clk);
    check("sb_done_empty", 64'(done_q.size()), 64'd0);
    check("sb_beat_empty", 64'(beat_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
